// File: rtl/ram_lane_pkg.sv
// Shared definitions for the byte-laned data memory: size codes, FSM states
// and the lane-mask helper.
package ram_lane_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // Lanes off .. off+nbytes-1, clipped to the widest (8-lane) word.
  function automatic logic [7:0] lane_mask(input logic [3:0] off, input logic [3:0] nbytes);
    logic [7:0] m;
    logic [4:0] hi;
    m  = 8'h00;
    hi = {1'b0, off} + {1'b0, nbytes};
    for (int i = 0; i < 8; i++) begin
      if ((5'(i) >= {1'b0, off}) && (5'(i) < hi)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_lane_ctrl_bank.sv
// One 8-bit byte lane of the data memory: async-reset clear, synchronous
// write, combinational read.
module ram_byte_bank #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [7:0] mem_r [DEPTH];

  // Storage: cleared by reset, written when this lane is enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/ram_lane_ctrl.sv
// Byte-laned single-port data memory with valid/ready requests, registered
// responses and word-crossing accesses split over two internal cycles.
module ram_lane_ctrl
  import ram_lane_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DWIDTH-1:0] resp_rdata
);

  localparam int         NB     = DWIDTH / 8;
  localparam int         OFFW   = $clog2(NB);
  localparam logic [1:0] MAX_SZ = (DWIDTH == 64) ? SZ_D : SZ_W;

  state_e              state_r, state_s;
  logic                ready_r;
  logic                resp_valid_r, resp_err_r;
  logic [DWIDTH-1:0]   resp_rdata_r;

  logic                we_r;
  logic [AWIDTH-1:0]   widx_r;
  logic [DWIDTH-1:0]   wdata_r;
  logic [3:0]          nbytes_r;
  logic [3:0]          cnt2_r;
  logic [OFFW:0]       rem_r;
  logic [DWIDTH-1:0]   part_r;

  logic [OFFW-1:0]     off_s;
  logic [AWIDTH-1:0]   widx_s;
  logic [3:0]          nbytes_s;
  logic [4:0]          sum_s;
  logic                cross_s, hi_bad_s, err_s, accept_s;

  logic                latch_s, fire_s, err_out_s;
  logic [NB-1:0]       lane_we_s;
  logic [DWIDTH-1:0]   wr_word_s;
  logic [AWIDTH-1:0]   bank_addr_s;
  logic [DWIDTH-1:0]   word_s;

  logic [3:0]          nb_sel_s;
  logic [NB-1:0]       bm_s;
  logic [DWIDTH-1:0]   rmask_s, rd1_s, rd2_s, resp_data_s;

  assign accept_s = req_valid && ready_r;

  // Request decode: address fields, crossing detection and error checks.
  always_comb begin
    off_s    = req_addr[OFFW-1:0];
    widx_s   = req_addr[AWIDTH+OFFW-1:OFFW];
    nbytes_s = 4'd1 << req_size;
    sum_s    = 5'(off_s) + 5'(nbytes_s);
    cross_s  = (sum_s > 5'(NB));
    hi_bad_s = ((req_addr >> (AWIDTH + OFFW)) != 32'd0);
    err_s    = (req_size > MAX_SZ) || hi_bad_s ||
               (cross_s && (widx_s == {AWIDTH{1'b1}}));
  end

  // FSM next state, write lanes/data and response strobes.
  always_comb begin
    state_s   = state_r;
    latch_s   = 1'b0;
    fire_s    = 1'b0;
    err_out_s = 1'b0;
    lane_we_s = {NB{1'b0}};
    wr_word_s = {DWIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        wr_word_s = req_wdata << {off_s, 3'b000};
        if (accept_s && !err_s && req_we) begin
          lane_we_s = NB'(lane_mask(4'(off_s), nbytes_s));
        end else begin
          lane_we_s = {NB{1'b0}};
        end
        if (accept_s) begin
          if (err_s) begin
            fire_s    = 1'b1;
            err_out_s = 1'b1;
          end else if (cross_s) begin
            state_s = SPLIT;
            latch_s = 1'b1;
          end else begin
            fire_s = 1'b1;
          end
        end else begin
          fire_s = 1'b0;
        end
      end
      SPLIT: begin
        // Remaining request bytes start at byte NB-off of the original data.
        wr_word_s = wdata_r >> {rem_r, 3'b000};
        if (we_r) begin
          lane_we_s = NB'(lane_mask(4'd0, cnt2_r));
        end else begin
          lane_we_s = {NB{1'b0}};
        end
        fire_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Word address shared by all lanes: second word during the split phase.
  always_comb begin
    if (state_r == SPLIT) begin
      bank_addr_s = widx_r + {{(AWIDTH-1){1'b0}}, 1'b1};
    end else begin
      bank_addr_s = widx_s;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    ram_byte_bank #(.AWIDTH(AWIDTH)) u_bank (
      .clk   (clk),
      .rstn  (rstn),
      .we    (lane_we_s[g]),
      .addr  (bank_addr_s),
      .wdata (wr_word_s[8*g +: 8]),
      .rdata (word_s[8*g +: 8])
    );
  end

  // Read-data alignment, size masking and split-read assembly.
  always_comb begin
    rd1_s = word_s >> {off_s, 3'b000};
    rd2_s = (word_s << {rem_r, 3'b000}) | part_r;
    if (state_r == SPLIT) begin
      nb_sel_s = nbytes_r;
    end else begin
      nb_sel_s = nbytes_s;
    end
    bm_s = NB'(lane_mask(4'd0, nb_sel_s));
    for (int i = 0; i < NB; i++) begin
      rmask_s[8*i +: 8] = {8{bm_s[i]}};
    end
    if (state_r == SPLIT) begin
      resp_data_s = we_r ? {DWIDTH{1'b0}} : (rd2_s & rmask_s);
    end else begin
      resp_data_s = (req_we || err_s) ? {DWIDTH{1'b0}} : (rd1_s & rmask_s);
    end
  end

  // State, handshake, response and split-context registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      ready_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {DWIDTH{1'b0}};
      we_r         <= 1'b0;
      widx_r       <= {AWIDTH{1'b0}};
      wdata_r      <= {DWIDTH{1'b0}};
      nbytes_r     <= 4'd0;
      cnt2_r       <= 4'd0;
      rem_r        <= {(OFFW+1){1'b0}};
      part_r       <= {DWIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      ready_r      <= (state_s == IDLE);
      resp_valid_r <= fire_s;
      if (fire_s) begin
        resp_err_r   <= err_out_s;
        resp_rdata_r <= resp_data_s;
      end
      if (latch_s) begin
        we_r     <= req_we;
        widx_r   <= widx_s;
        wdata_r  <= req_wdata;
        nbytes_r <= nbytes_s;
        cnt2_r   <= 4'(sum_s - 5'(NB));
        rem_r    <= (OFFW+1)'(NB) - (OFFW+1)'(off_s);
        part_r   <= rd1_s;
      end
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_ram_lane_ctrl.sv
// Directed and randomized checks of ram_lane_ctrl against a byte-array model.
module tb_ram_lane_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;
  localparam int TOT = (1 << AW) * NB;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_we;
  logic [1:0]    req_size;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  byte unsigned  mem_m [TOT];
  logic          exp_err, exp_cross;
  logic [DW-1:0] exp_rd;

  ram_lane_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TOT; i++) mem_m[i] = 8'h00;
  endtask

  // Byte-by-byte reference: byte k of the request lives at address addr+k.
  task automatic model_access(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [DW-1:0] wd);
    longint a, nb;
    a  = longint'(addr);
    nb = longint'(1) << size;
    exp_rd    = '0;
    exp_cross = ((a % NB) + nb) > NB;
    exp_err   = (a >= TOT) || (nb > NB) || (a + nb > TOT);
    if (!exp_err) begin
      for (int k = 0; k < nb; k++) begin
        if (we) mem_m[a + k] = wd[8*k +: 8];
        else    exp_rd[8*k +: 8] = mem_m[a + k];
      end
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [DW-1:0] wd);
    int n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_req", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
    model_access(we, size, addr, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag);
    if (exp_cross && !exp_err) begin
      chk({tag, "_mid_valid"}, {63'd0, resp_valid}, 64'd0);
      chk({tag, "_mid_ready"}, {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, exp_err});
    chk({tag, "_rdata"}, 64'(resp_rdata), 64'(exp_rd));
  endtask

  initial begin
    logic        rwe;
    logic [1:0]  rsz;
    logic [31:0] raddr;

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = '0;
    model_clear();

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_err", {63'd0, resp_err}, 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
    send(1'b0, 2'd2, 32'h24, '0); expect_resp("idle_read");
    chk("idle_read_lit", 64'(resp_rdata), 64'd0);

    // 2: aligned word write then read, back to back
    send(1'b1, 2'd2, 32'h10, 32'hDEADBEEF); expect_resp("w_word");
    send(1'b0, 2'd2, 32'h10, '0); expect_resp("r_word");
    chk("r_word_lit", 64'(resp_rdata), 64'hDEADBEEF);
    @(posedge clk); #1;
    chk("pulse_single", {63'd0, resp_valid}, 64'd0);

    // 3: byte and half accesses
    send(1'b1, 2'd0, 32'h13, 32'hFFFF_FFAB); expect_resp("w_byte");
    send(1'b0, 2'd2, 32'h10, '0); expect_resp("r_after_byte");
    chk("r_after_byte_lit", 64'(resp_rdata), 64'hABADBEEF);
    send(1'b0, 2'd1, 32'h12, '0); expect_resp("r_half");
    chk("r_half_lit", 64'(resp_rdata), 64'h0000ABAD);

    // 4: word-crossing accesses
    send(1'b1, 2'd2, 32'h0E, 32'h11223344); expect_resp("w_cross");
    send(1'b0, 2'd2, 32'h0C, '0); expect_resp("r_lo_word");
    chk("r_lo_word_lit", 64'(resp_rdata), 64'h33440000);
    send(1'b0, 2'd2, 32'h10, '0); expect_resp("r_hi_word");
    chk("r_hi_word_lit", 64'(resp_rdata), 64'hABAD1122);
    send(1'b0, 2'd2, 32'h0E, '0); expect_resp("r_cross");
    chk("r_cross_lit", 64'(resp_rdata), 64'h11223344);

    // 5: errors leave memory untouched
    send(1'b1, 2'd2, 32'(TOT), 32'hCAFEF00D); expect_resp("err_range");
    chk("err_range_flag", {63'd0, resp_err}, 64'd1);
    send(1'b1, 2'd2, 32'(TOT - 2), 32'h55667788); expect_resp("err_wrap");
    chk("err_wrap_flag", {63'd0, resp_err}, 64'd1);
    send(1'b0, 2'd2, 32'h0, '0); expect_resp("no_wrap_word0");
    chk("no_wrap_word0_lit", 64'(resp_rdata), 64'd0);
    send(1'b0, 2'd3, 32'h10, '0); expect_resp("err_size");
    chk("err_size_flag", {63'd0, resp_err}, 64'd1);

    // randomized traffic against the byte model
    for (int t = 0; t < 300; t++) begin
      rwe   = 1'($urandom_range(0, 1));
      rsz   = 2'($urandom_range(0, 3));
      raddr = 32'($urandom_range(0, TOT + 7));
      if ($urandom_range(0, 15) == 0) raddr = raddr | 32'h8000_0000;
      send(rwe, rsz, raddr, DW'($urandom));
      expect_resp("rand");
    end

    // 6: reset during the split phase of a crossing write
    send(1'b1, 2'd2, 32'h0E, 32'hA1B2C3D4);
    rstn = 1'b0;
    model_clear();
    #1;
    chk("splitrst_valid", {63'd0, resp_valid}, 64'd0);
    chk("splitrst_ready", {63'd0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("splitrst_valid2", {63'd0, resp_valid}, 64'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("splitrst_ready_after", {63'd0, req_ready}, 64'd1);
    chk("splitrst_no_resp", {63'd0, resp_valid}, 64'd0);
    send(1'b0, 2'd2, 32'h0C, '0); expect_resp("splitrst_lo");
    chk("splitrst_lo_lit", 64'(resp_rdata), 64'd0);
    send(1'b0, 2'd2, 32'h10, '0); expect_resp("splitrst_hi");
    chk("splitrst_hi_lit", 64'(resp_rdata), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
